// File: rtl/button_event_fifo_if.sv
// CPU-side register access bundle for button_event_fifo: select, decode strobe, read data.
interface button_event_fifo_if;
  logic        a0;
  logic        ack;
  logic [15:0] data_out;

  modport master (output a0, output ack, input data_out);
  modport slave  (input a0, input ack, output data_out);
endinterface

// File: rtl/button_event_fifo.sv
// Debounced push-button peripheral queuing one 16-bit event word per press in a small FIFO.
// Optional BUTTON_FIFO_TIMESTAMP_EN replaces the sequence word with {seq[3:0], ms[11:0]}.
module button_event_fifo #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enter_key,
  button_event_fifo_if.slave bus
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned PW     = AW + 1;
  localparam int unsigned CW     = $clog2(DEBOUNCE_CYCLES);

  logic              sync_meta, sync_level;
  logic              db_level, db_prev, db_level_nxt;
  logic [CW-1:0]     db_cnt, db_cnt_nxt;
  logic              rd_data_q, rd_stat_q;
  logic [WORD_W-1:0] seq;
  logic [PW-1:0]     wp, rp, count, count_nxt;
  logic              ovf, ovf_nxt;
  logic [WORD_W-1:0] mem [FIFO_DEPTH];

  logic              rd_data_c, rd_stat_c, pop_rise_c, stat_rise_c;
  logic              press_c, empty_c, full_c, pop_c, push_c, drop_c;
  logic [WORD_W-1:0] word_c;

  // Debounce: count consecutive mismatching cycles, flip after DEBOUNCE_CYCLES of them
  always_comb begin
    db_level_nxt = db_level;
    db_cnt_nxt   = '0;
    if (sync_level != db_level) begin
      if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        db_level_nxt = sync_level;
        db_cnt_nxt   = '0;
      end else begin
        db_cnt_nxt = db_cnt + CW'(1);
      end
    end
  end

  // Access strobes are edge-detected so a held ack acts only once
  always_comb begin
    rd_data_c   = bus.ack & ~bus.a0;
    rd_stat_c   = bus.ack & bus.a0;
    pop_rise_c  = rd_data_c & ~rd_data_q;
    stat_rise_c = rd_stat_c & ~rd_stat_q;
    press_c     = db_prev & ~db_level;
    empty_c     = (count == '0);
    full_c      = (count == PW'(FIFO_DEPTH));
    pop_c       = pop_rise_c & ~empty_c;
    push_c      = press_c & (~full_c | pop_c);
    drop_c      = press_c & full_c & ~pop_c;
  end

  always_comb begin
    count_nxt = count;
    if (push_c && !pop_c) count_nxt = count + PW'(1);
    else if (pop_c && !push_c) count_nxt = count - PW'(1);
    ovf_nxt = ovf;
    if (stat_rise_c) ovf_nxt = 1'b0;
    if (drop_c) ovf_nxt = 1'b1;
  end

`ifdef BUTTON_FIFO_TIMESTAMP_EN
  logic [CW-1:0] ms_div;
  logic [11:0]   ms;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_div <= '0;
      ms     <= '0;
    end else if (ms_div == CW'(DEBOUNCE_CYCLES - 1)) begin
      ms_div <= '0;
      ms     <= ms + 12'(1);
    end else begin
      ms_div <= ms_div + CW'(1);
    end
  end

  assign word_c = {seq[3:0], ms};
`else
  assign word_c = seq;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta  <= 1'b1;
      sync_level <= 1'b1;
      db_level   <= 1'b1;
      db_prev    <= 1'b1;
      db_cnt     <= '0;
      rd_data_q  <= 1'b0;
      rd_stat_q  <= 1'b0;
      seq        <= '0;
      wp         <= '0;
      rp         <= '0;
      count      <= '0;
      ovf        <= 1'b0;
    end else begin
      sync_meta  <= enter_key;
      sync_level <= sync_meta;
      db_level   <= db_level_nxt;
      db_prev    <= db_level;
      db_cnt     <= db_cnt_nxt;
      rd_data_q  <= rd_data_c;
      rd_stat_q  <= rd_stat_c;
      if (press_c) seq <= seq + WORD_W'(1);
      if (push_c)  wp  <= wp + PW'(1);
      if (pop_c)   rp  <= rp + PW'(1);
      count      <= count_nxt;
      ovf        <= ovf_nxt;
    end
  end

  // Storage needs no reset: the read mux masks it while empty
  always_ff @(posedge clk) begin
    if (push_c) mem[wp[AW-1:0]] <= word_c;
  end

  always_comb begin
    if (bus.a0) bus.data_out = {8'(count), 6'b0, ovf, ~empty_c};
    else if (empty_c) bus.data_out = '0;
    else bus.data_out = mem[rp[AW-1:0]];
  end

endmodule
